// File: rtl/sar_search_pkg.sv
// Shared types and defaults for the successive-approximation search controller.
// The optional cmp_ack timeout is enabled with the SAR_TIMEOUT_EN macro.
package sar_search_pkg;

   typedef enum logic [1:0] {
      SAR_IDLE = 2'd0,
      SAR_TRY  = 2'd1,
      SAR_DONE = 2'd2
   } sar_state_e;

   localparam int SAR_N_DEF       = 8;
   localparam int SAR_TIMEOUT_DEF = 16;

   // Mask with only bit (width-1) set; converts between offset-binary and two's complement.
   function automatic logic [63:0] sar_msb_mask(input int unsigned width);
      sar_msb_mask = 64'd1 << (width - 32'd1);
   endfunction

endpackage

// File: rtl/sar_search.sv
// Successive-approximation controller driving a signed less-than comparator.
// Define SAR_TIMEOUT_EN to build the per-step cmp_ack timeout and the error flag.
module sar_search
   import sar_search_pkg::*;
#(
   parameter int N       = SAR_N_DEF,
   parameter int TIMEOUT = SAR_TIMEOUT_DEF
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   output logic         busy,
   output logic         cmp_req,
   output logic [N-1:0] guess,
   input  logic         cmp_ack,
   input  logic         cmp_lt,
   output logic         done,
   output logic [N-1:0] result,
   output logic         error
);

   localparam int             IDX_W    = $clog2(N);
   localparam logic [N-1:0]   MSB_MASK = N'(sar_msb_mask(N));
   localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(N - 1);

   sar_state_e       state_q, state_d;
   logic [N-1:0]     u_q, u_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [IDX_W-1:0] idx_dec_s;
   logic [N-1:0]     guess_q, guess_d;
   logic [N-1:0]     result_q, result_d;
   logic             busy_q, busy_d;
   logic             cmp_req_q, cmp_req_d;
   logic             done_q, done_d;

`ifdef SAR_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             error_q, error_d;
`endif

   assign idx_dec_s = idx_q - IDX_W'(1);

   // Next-state, trial-value and output computation.
   always_comb begin
      state_d  = state_q;
      u_d      = u_q;
      idx_d    = idx_q;
      result_d = result_q;
`ifdef SAR_TIMEOUT_EN
      cnt_d    = cnt_q;
      error_d  = error_q;
`endif
      case (state_q)
         SAR_IDLE: begin
            if (start) begin
               state_d = SAR_TRY;
               u_d     = MSB_MASK;
               idx_d   = IDX_TOP;
`ifdef SAR_TIMEOUT_EN
               cnt_d   = {CNT_W{1'b0}};
               error_d = 1'b0;
`endif
            end else begin
               state_d = SAR_IDLE;
            end
         end
         SAR_TRY: begin
            if (cmp_ack) begin
`ifdef SAR_TIMEOUT_EN
               cnt_d = {CNT_W{1'b0}};
`endif
               if (cmp_lt) begin
                  u_d[idx_q] = 1'b0;
               end else begin
                  u_d[idx_q] = u_q[idx_q];
               end
               if (idx_q != {IDX_W{1'b0}}) begin
                  u_d[idx_dec_s] = 1'b1;
                  idx_d          = idx_dec_s;
               end else begin
                  state_d  = SAR_DONE;
                  result_d = u_d ^ MSB_MASK;
               end
            end else begin
`ifdef SAR_TIMEOUT_EN
               // A comparator that never answers aborts the conversion with result 0.
               if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                  state_d  = SAR_DONE;
                  error_d  = 1'b1;
                  result_d = {N{1'b0}};
                  cnt_d    = {CNT_W{1'b0}};
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
`else
               state_d = SAR_TRY;
`endif
            end
         end
         SAR_DONE: begin
            state_d = SAR_IDLE;
         end
         default: begin
            state_d = SAR_IDLE;
         end
      endcase

      busy_d    = (state_d == SAR_TRY);
      cmp_req_d = (state_d == SAR_TRY);
      done_d    = (state_d == SAR_DONE);
      if (state_d == SAR_TRY) begin
         guess_d = u_d ^ MSB_MASK;
      end else begin
         guess_d = guess_q;
      end
   end

   // State and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= SAR_IDLE;
         u_q       <= {N{1'b0}};
         idx_q     <= IDX_TOP;
         guess_q   <= {N{1'b0}};
         result_q  <= {N{1'b0}};
         busy_q    <= 1'b0;
         cmp_req_q <= 1'b0;
         done_q    <= 1'b0;
`ifdef SAR_TIMEOUT_EN
         cnt_q     <= {CNT_W{1'b0}};
         error_q   <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         u_q       <= u_d;
         idx_q     <= idx_d;
         guess_q   <= guess_d;
         result_q  <= result_d;
         busy_q    <= busy_d;
         cmp_req_q <= cmp_req_d;
         done_q    <= done_d;
`ifdef SAR_TIMEOUT_EN
         cnt_q     <= cnt_d;
         error_q   <= error_d;
`endif
      end
   end

   assign busy    = busy_q;
   assign cmp_req = cmp_req_q;
   assign guess   = guess_q;
   assign done    = done_q;
   assign result  = result_q;

`ifdef SAR_TIMEOUT_EN
   assign error = error_q;
`else
   // TIMEOUT only matters when the abort counter is built.
   logic unused_timeout_s;
   assign unused_timeout_s = ^TIMEOUT;
   assign error = 1'b0;
`endif

endmodule

// File: tb/tb_sar_search.sv
// Scoreboard bench for sar_search: stimulus pushes expected results/guesses,
// a monitor pops and compares them whenever the DUT presents done or cmp_req.
module tb_sar_search;

   localparam int N = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic         busy;
   logic         cmp_req;
   logic [N-1:0] guess;
   logic         cmp_ack;
   logic         cmp_lt;
   logic         done;
   logic [N-1:0] result;
   logic         error;
   logic         hold_ack;
   logic [N-1:0] target;

   typedef struct {
      logic [N-1:0] res;
      int           cyc;
      logic         err;
   } exp_t;

   exp_t         exp_q[$];
   logic [N-1:0] gexp_q[$];
   exp_t         mon_e;
   int           n_cmp = 0;
   int           n_bad = 0;
   int           cyc = 0;

   always #5 clk = ~clk;

   // Signed less-than responder: a = target, b = guess; ack follows req unless stalled.
   assign cmp_lt  = ($signed(target) < $signed(guess));
   assign cmp_ack = cmp_req & ~hold_ack;

   sar_search #(.N(N), .TIMEOUT(16)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .busy    (busy),
      .cmp_req (cmp_req),
      .guess   (guess),
      .cmp_ack (cmp_ack),
      .cmp_lt  (cmp_lt),
      .done    (done),
      .result  (result),
      .error   (error)
   );

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: samples after the stimulus edge, well before the next rising edge.
   always begin
      @(posedge clk);
      #7;
      if (cmp_req && gexp_q.size() > 0) begin
         chk("guess", 32'(guess), 32'(gexp_q[0]));
         if (cmp_ack) void'(gexp_q.pop_front());
      end
      if (done) begin
         if (exp_q.size() == 0) begin
            chk("done_unexpected", 32'(done), 32'd0);
         end else begin
            mon_e = exp_q.pop_front();
            chk("result", 32'(result), 32'(mon_e.res));
            chk("done_cycle", 32'(cyc), 32'(mon_e.cyc));
            chk("error_at_done", 32'(error), 32'(mon_e.err));
         end
      end
   end

   task automatic push_guesses(input logic [63:0] seq);
      for (int i = 7; i >= 0; i--) gexp_q.push_back(seq[i*8 +: 8]);
   endtask

   // Called at a falling edge in cycle c; returns at the falling edge of cycle c+1.
   task automatic start_conv(input logic [N-1:0] tgt, input logic [N-1:0] res,
                             input int extra, input bit expect_done, input logic err);
      target = tgt;
      start  = 1'b1;
      if (expect_done) exp_q.push_back('{res, cyc + 9 + extra, err});
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_drain();
      int k = 0;
      while (exp_q.size() != 0 && k < 200) begin
         @(negedge clk);
         k++;
      end
      chk("drain_pending", 32'(exp_q.size()), 32'd0);
      chk("guess_pending", 32'(gexp_q.size()), 32'd0);
      exp_q.delete();
      gexp_q.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish by 200000, expected earlier completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int st[8];
      int total;
      logic [N-1:0] ext[3];

      rst = 1'b1; start = 1'b0; hold_ack = 1'b0; target = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_cmp_req", 32'(cmp_req), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_result", 32'(result), 32'd0);
      chk("rst_guess", 32'(guess), 32'd0);
      chk("rst_error", 32'(error), 32'd0);
      @(negedge clk);

      // target -5, ack tied high
      push_guesses(64'h00C0_E0F0_F8FC_FAFB);
      start_conv(8'hFB, 8'hFB, 0, 1'b1, 1'b0);
      wait_drain();

      // extremes and zero
      ext[0] = 8'h80; ext[1] = 8'h7F; ext[2] = 8'h00;
      for (int i = 0; i < 3; i++) begin
         start_conv(ext[i], ext[i], 0, 1'b1, 1'b0);
         wait_drain();
      end

      // target 37 with 2-cycle ack stalls on a random subset of steps
      total = 0;
      for (int i = 0; i < 8; i++) begin
         st[i] = (i == 1) ? 1 : int'($urandom_range(0, 1));
         total += 2 * st[i];
      end
      push_guesses(64'h0040_2030_2824_2625);
      start_conv(8'h25, 8'h25, total, 1'b1, 1'b0);
      for (int s = 0; s < 8; s++) begin
         if (st[s] != 0) begin
            hold_ack = 1'b1;
            repeat (2) @(negedge clk);
            hold_ack = 1'b0;
         end
         @(negedge clk);
      end
      wait_drain();

      // reset at step 4, then target -1
      start_conv(8'd100, 8'd0, 0, 1'b0, 1'b0);
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_cmp_req", 32'(cmp_req), 32'd0);
      chk("midrst_done", 32'(done), 32'd0);
      chk("midrst_result", 32'(result), 32'd0);
      push_guesses(64'h00C0_E0F0_F8FC_FEFF);
      start_conv(8'hFF, 8'hFF, 0, 1'b1, 1'b0);
      wait_drain();

      // start held high: second conversion accepted in the IDLE cycle after DONE
      target = 8'h33;
      start  = 1'b1;
      exp_q.push_back('{8'h33, cyc + 9, 1'b0});
      exp_q.push_back('{8'h33, cyc + 19, 1'b0});
      repeat (11) @(negedge clk);
      start = 1'b0;
      wait_drain();

`ifdef SAR_TIMEOUT_EN
      // ack withheld from step 2 onwards: abort after 16 stall cycles
      start_conv(8'h10, 8'h00, 10, 1'b1, 1'b1);
      repeat (2) @(negedge clk);
      hold_ack = 1'b1;
      wait_drain();
      hold_ack = 1'b0;
      chk("error_held", 32'(error), 32'd1);
      start_conv(8'h05, 8'h05, 0, 1'b1, 1'b0);
      chk("error_cleared", 32'(error), 32'd0);
      wait_drain();
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/sar_search.md
Name: sar_search

Overview:
- Successive-approximation controller; the initiator end of a signed less-than compare interface.
- Drives a trial value to an external comparator and reads back one lt bit per step. After N steps it holds the two's-complement value of the hidden operand.
- Used to digitise a value that is only observable through comparisons (SAR ADC front end, threshold calibration). The comparator slot is filled by the team's structural signed less-than block.

Parameters:
- N, 8, width of trial and result in bits (two's complement), N >= 2
- TIMEOUT, 16, max cycles to wait for cmp_ack per step (used only with the optional feature)

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request a conversion; accepted only when busy=0
- busy  output  1  high from the cycle after an accepted start until done
- cmp_req  output  1  high while guess is valid and awaiting a compare
- guess  output  N  signed trial value presented to the comparator
- cmp_ack  input  1  comparator response valid this cycle (may be combinational from cmp_req)
- cmp_lt  input  1  sampled when cmp_ack=1: 1 means target < guess (signed)
- done  output  1  one-cycle pulse when result is updated
- result  output  N  signed converged value; held until the next done
- error  output  1  timeout flag (tied 0 unless SAR_TIMEOUT_EN)

Behaviour:
- Reset: state=IDLE, busy=0, cmp_req=0, guess=0, done=0, result=0, error=0, bit index=N-1.
- Internal trial u is offset-binary. guess = u with its MSB inverted, so u=0x80 maps to guess 0 for N=8.
- IDLE:
  - start=1 loads u = 1<<(N-1), idx=N-1, clears error.
  - Next state is TRY; busy=1.
  - start while busy is ignored.
- TRY:
  - cmp_req=1, guess driven from u.
  - Wait while cmp_ack=0; guess is held stable.
  - On cmp_ack=1: if cmp_lt=1, clear u[idx]; else keep it.
  - If idx>0: set u[idx-1], decrement idx, stay in TRY. Next compare is in the following cycle at the earliest, with cmp_req staying high.
  - If idx=0: go to DONE.
- DONE (1 cycle):
  - result = u with MSB inverted; done=1, busy=0, cmp_req=0.
  - Next state is IDLE.
  - A start asserted during DONE is ignored; it must be re-asserted in IDLE.
- Latency with cmp_ack tied high: start accepted at cycle 0, N compare cycles (1..N), done in cycle N+1. Each ack stall adds one cycle.
- Convergence: result is the largest value v with !(target < v), so result = target for every target in [-2^(N-1), 2^(N-1)-1], extremes included.
- rst mid-conversion: abandons the conversion and returns to the reset state next cycle. result is cleared to 0.
- cmp_lt is ignored when cmp_ack=0. cmp_ack is ignored outside TRY.

Optional Feature:
- Macro SAR_TIMEOUT_EN.
- Defined:
  - A per-step counter counts TRY cycles with cmp_ack=0 and resets to 0 on each ack.
  - On reaching TIMEOUT: abort to DONE with error=1, done=1, result=0.
  - error holds until the next accepted start or rst.
- Undefined: no counter is built, error is tied 0, and TRY waits for cmp_ack indefinitely.

Decomposition:
- Shared package holds:
  - state enum (SAR_IDLE, SAR_TRY, SAR_DONE)
  - helper constant for the MSB mask
  - default N and TIMEOUT
- No sub-module is needed in the controller itself.
- The bench instantiates the team's signed less-than comparator as the responder: a=target, b=guess, lt -> cmp_lt, cmp_ack=cmp_req.

Test Plan:
- N=8, target=-5, ack tied high:
  - guess sequence 0x00, 0xC0, 0xE0, 0xF0, 0xF8, 0xFC, 0xFA, 0xFB
  - done in cycle 9; result=0xFB
- Targets -128, 127 and 0: result 0x80, 0x7F and 0x00 respectively; each completes in exactly 9 cycles.
- Random 2-cycle ack stalls, target=37:
  - guess stable during stalls; result=0x25
  - latency = 9 + total stall cycles
- rst pulsed at step 4 of a conversion, then a new start with target=-1: busy, cmp_req and done are 0 the cycle after rst; second conversion gives result=0xFF.
- start held high through a whole conversion: exactly one conversion per IDLE entry; a second conversion begins the cycle after DONE.
- SAR_TIMEOUT_EN, TIMEOUT=16, ack withheld at step 2: after 16 stall cycles, done=1, error=1, result=0; the next start clears error.
